// File: rtl/lat_logger_if.sv
// Purpose : bundles the control, sample, readout and status signals of lat_logger.
// Latency : none, wires only.
// Backpressure: none; every transfer is a single-cycle pulse or level.
// Ports   : master drives arm/clear/sample/end_rd/readout requests, slave (lat_logger) returns
//           rd_valid/rd_data and the run status and statistics.
interface lat_logger_if #(
    parameter int LAT_WIDTH = 16,
    parameter int AW        = 10
);
    logic                 arm;
    logic                 clear;
    logic                 lat_timer_valid;
    logic [LAT_WIDTH-1:0] lat_timer;
    logic                 end_rd;
    logic                 rd_req;
    logic [AW-1:0]        rd_addr;
    logic                 rd_valid;
    logic [LAT_WIDTH-1:0] rd_data;
    logic                 busy;
    logic                 done;
    logic [AW:0]          stored;
    logic [31:0]          sample_cnt;
    logic                 overflow;
    logic [LAT_WIDTH-1:0] lat_min;
    logic [LAT_WIDTH-1:0] lat_max;
    logic [47:0]          lat_sum;

    modport master (
        output arm, clear, lat_timer_valid, lat_timer, end_rd, rd_req, rd_addr,
        input  rd_valid, rd_data, busy, done, stored, sample_cnt, overflow,
               lat_min, lat_max, lat_sum
    );

    modport slave (
        input  arm, clear, lat_timer_valid, lat_timer, end_rd, rd_req, rd_addr,
        output rd_valid, rd_data, busy, done, stored, sample_cnt, overflow,
               lat_min, lat_max, lat_sum
    );
endinterface

// File: rtl/lat_logger.sv
// Purpose : records per-read latency samples into a buffer and keeps count/sum/min/max.
// Latency : statistics visible one cycle after a sample; rd_data valid one cycle after rd_req.
// Backpressure: none; samples past DEPTH are counted in the statistics but flagged as overflow.
// Ports   : clk, rst (async active-high); bus (slave) carries arm/clear, lat_timer samples,
//           end_rd, the rd_req/rd_addr readout port and all status/statistics outputs.
module lat_logger #(
    parameter int DEPTH     = 1024,
    parameter int LAT_WIDTH = 16,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    lat_logger_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [31:0] CNT_MAX = '1;

    state_t               state;
    logic                 busy_q;
    logic                 done_q;
    logic [AW:0]          stored_q;
    logic [31:0]          cnt_q;
    logic                 ovf_q;
    logic [LAT_WIDTH-1:0] min_q;
    logic [LAT_WIDTH-1:0] max_q;
    logic [47:0]          sum_q;
    logic                 rd_valid_q;
    logic                 rd_hit;
    logic [LAT_WIDTH-1:0] ram_q;
    logic                 wr_en;

    logic [LAT_WIDTH-1:0] mem [DEPTH];

    // arm/clear take priority over a sample arriving in the same cycle.
    assign wr_en = (state == RECORD) && bus.lat_timer_valid && !bus.arm && !bus.clear
                   && (stored_q != FULL);

    // Plain synchronous RAM: one write port, one read port, contents never reset.
    // Non-blocking read of the same address being written returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[stored_q[AW-1:0]] <= bus.lat_timer;
        end
        if (bus.rd_req) begin
            ram_q <= mem[bus.rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            stored_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            min_q      <= '1;
            max_q      <= '0;
            sum_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_hit     <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req;
            // rd_hit gates the unreset RAM output, so stale or undefined words read as zero.
            if (bus.rd_req) begin
                rd_hit <= ({1'b0, bus.rd_addr} < stored_q);
            end

            if (bus.clear || bus.arm) begin
                state    <= bus.clear ? IDLE : RECORD;
                busy_q   <= !bus.clear;
                done_q   <= 1'b0;
                stored_q <= '0;
                cnt_q    <= '0;
                ovf_q    <= 1'b0;
                min_q    <= '1;
                max_q    <= '0;
                sum_q    <= '0;
            end else if (state == RECORD) begin
                if (bus.lat_timer_valid) begin
                    if (stored_q != FULL) begin
                        stored_q <= stored_q + (AW+1)'(1);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    // Freezing everything once the count saturates keeps sum from wrapping.
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 32'd1;
                        sum_q <= sum_q + 48'(bus.lat_timer);
                        if (bus.lat_timer < min_q) begin
                            min_q <= bus.lat_timer;
                        end
                        if (bus.lat_timer > max_q) begin
                            max_q <= bus.lat_timer;
                        end
                    end
                end
                if (bus.end_rd) begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_hit ? ram_q : '0;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stored     = stored_q;
    assign bus.sample_cnt = cnt_q;
    assign bus.overflow   = ovf_q;
    assign bus.lat_min    = min_q;
    assign bus.lat_max    = max_q;
    assign bus.lat_sum    = sum_q;
endmodule

// File: tb/tb_lat_logger.sv
// Purpose : randomized and directed stimulus for lat_logger, scored against a queue-based model.
// Latency : expected read data is queued at request time and popped when rd_valid appears.
// Backpressure: none; the bench issues at most one request per cycle.
module tb_lat_logger;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lat_logger_if #(.LAT_WIDTH(16), .AW(AW)) bus();

    lat_logger #(.DEPTH(DEPTH), .LAT_WIDTH(16), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;
    int sbq[$];
    int last_rd = 0;

    // Reference model: buffer as a bounded queue, statistics as plain numbers.
    int     mq[$];
    longint m_cnt;
    longint m_sum;
    int     m_min;
    int     m_max;
    bit     m_ovf;
    int     m_st;      // 0 idle, 1 recording, 2 done

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt = 0;
        m_sum = 0;
        m_min = 65535;
        m_max = 0;
        m_ovf = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},       bus.busy,       64'(m_st == 1));
        chk({tag, ".done"},       bus.done,       64'(m_st == 2));
        chk({tag, ".stored"},     bus.stored,     64'(mq.size()));
        chk({tag, ".sample_cnt"}, bus.sample_cnt, m_cnt);
        chk({tag, ".overflow"},   bus.overflow,   64'(m_ovf));
        chk({tag, ".lat_min"},    bus.lat_min,    64'(m_min));
        chk({tag, ".lat_max"},    bus.lat_max,    64'(m_max));
        chk({tag, ".lat_sum"},    bus.lat_sum,    m_sum);
    endtask

    // One clock of stimulus: inputs applied now, sampled at the next rising edge.
    task automatic cyc(input bit a, input bit c, input bit v, input int val,
                       input bit e, input bit r, input int addr);
        int ai;
        bus.arm = a;
        bus.clear = c;
        bus.lat_timer_valid = v;
        bus.lat_timer = 16'(val);
        bus.end_rd = e;
        bus.rd_req = r;
        bus.rd_addr = AW'(addr);
        ai = addr % DEPTH;
        if (r) sbq.push_back(ai < mq.size() ? mq[ai] : 0);
        if (c) begin
            model_reset();
            m_st = 0;
        end else if (a) begin
            model_reset();
            m_st = 1;
        end else if (m_st == 1) begin
            if (v) begin
                if (mq.size() < DEPTH) mq.push_back(val);
                else m_ovf = 1;
                if (m_cnt != 64'hFFFF_FFFF) begin
                    m_cnt++;
                    m_sum += val;
                    if (val < m_min) m_min = val;
                    if (val > m_max) m_max = val;
                end
            end
            if (e) m_st = 2;
        end
        @(posedge clk);
        #1;
        bus.arm = 0;
        bus.clear = 0;
        bus.lat_timer_valid = 0;
        bus.end_rd = 0;
        bus.rd_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(input int val);
        cyc(0, 0, 1, val, 0, 0, 0);
    endtask

    task automatic rd(input int addr);
        cyc(0, 0, 0, 0, 0, 1, addr);
    endtask

    // Monitor: every rd_valid cycle consumes exactly one queued expectation.
    always @(negedge clk) begin
        int e;
        if (!rst && bus.rd_valid) begin
            if (sbq.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("rd_data", bus.rd_data, 64'(e));
                last_rd = e;
            end
        end
    end

    initial begin
        bus.arm = 0; bus.clear = 0; bus.lat_timer_valid = 0; bus.lat_timer = 0;
        bus.end_rd = 0; bus.rd_req = 0; bus.rd_addr = 0;
        model_reset();
        m_st = 0;
        #12;
        check_model("reset");
        chk("reset.rd_valid", bus.rd_valid, 0);
        chk("reset.rd_data", bus.rd_data, 0);

        // Release between edges; the very next edge must take arm.
        @(negedge clk);
        rst = 0;

        // Basic run
        cyc(1, 0, 0, 0, 0, 0, 0);
        sample(100);
        sample(40);
        sample(250);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check_model("basic");
        chk("basic.done_const", bus.done, 1);
        chk("basic.stored_const", bus.stored, 3);
        chk("basic.cnt_const", bus.sample_cnt, 3);
        chk("basic.min_const", bus.lat_min, 40);
        chk("basic.max_const", bus.lat_max, 250);
        chk("basic.sum_const", bus.lat_sum, 390);
        rd(1);
        idle(1);
        chk("basic.rd1_const", last_rd, 40);
        rd(0); rd(1); rd(2); rd(3);
        idle(3);
        chk("rd_hold", bus.rd_data, 64'(last_rd));

        // Samples and end_rd in DONE change nothing
        sample(5);
        cyc(0, 0, 1, 1, 1, 0, 0);
        check_model("done_ignore");

        // Overflow run, then a short run reading past stored
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) sample(7);
        check_model("ovf");
        chk("ovf.stored_const", bus.stored, 16);
        chk("ovf.cnt_const", bus.sample_cnt, 20);
        chk("ovf.flag_const", bus.overflow, 1);
        chk("ovf.sum_const", bus.lat_sum, 140);
        rd(15);
        rd(16);
        cyc(0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) sample(7);
        rd(12);
        idle(1);
        chk("short.rd12_const", last_rd, 0);
        cyc(0, 0, 1, 8, 0, 1, 10);     // write and read of index 10 in one cycle
        check_model("short");

        // Sample together with end_rd
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 33, 1, 0, 0);
        check_model("valid_end");
        chk("valid_end.cnt_const", bus.sample_cnt, 1);

        // arm and clear together: clear wins
        sample(3);
        cyc(1, 1, 0, 0, 0, 0, 0);
        check_model("arm_clear");
        chk("arm_clear.busy_const", bus.busy, 0);

        // Re-arm from DONE with three stored samples
        cyc(1, 0, 0, 0, 0, 0, 0);
        sample(20); sample(30); sample(40);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        sample(9);
        check_model("rearm");
        chk("rearm.min_const", bus.lat_min, 9);
        chk("rearm.stored_const", bus.stored, 1);

        // Asynchronous reset mid-run, with a read response outstanding
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) sample(50 + i);
        cyc(0, 0, 1, 60, 0, 1, 0);
        #2;
        rst = 1;
        #1;
        model_reset();
        m_st = 0;
        sbq.delete();
        last_rd = 0;
        check_model("rst_async");
        chk("rst_async.rd_valid", bus.rd_valid, 0);
        chk("rst_async.rd_data", bus.rd_data, 0);
        @(negedge clk);
        rst = 0;
        sample(11); sample(12); sample(13);
        check_model("no_arm");

        // Randomized runs
        for (int run = 0; run < 8; run++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            for (int i = 0; i < 60; i++) begin
                cyc(0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
                    int'($urandom_range(0, 65535)), ($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 30), int'($urandom_range(0, DEPTH - 1)));
            end
            check_model($sformatf("rand%0d", run));
        end

        idle(2);
        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/lat_logger.md
LAT_LOGGER -- requirements
Module: lat_logger

Interface
REQ-001 Parameter DEPTH, 1024: number of latency samples stored; power of two, 16 to 65536.
REQ-002 Parameter LAT_WIDTH, 16: width of one latency sample.
REQ-003 Parameter AW, log2(DEPTH): sample buffer address width.
REQ-004 The ports SHALL be:
- clk, input, 1: single clock for all logic.
- rst, input, 1: asynchronous, active-high reset.
- arm, input, 1: one-cycle pulse; clears all results and starts recording.
- clear, input, 1: one-cycle pulse; clears all results and returns to IDLE.
- lat_timer_valid, input, 1: one latency sample is present this cycle.
- lat_timer, input, LAT_WIDTH: latency sample from the read engine.
- end_rd, input, 1: the read engine has finished its run.
- rd_req, input, 1: host readout request.
- rd_addr, input, AW: index of the sample to read.
- rd_valid, output, 1: rd_data is valid.
- rd_data, output, LAT_WIDTH: the sample that was read.
- busy, output, 1: the block is in RECORD.
- done, output, 1: the block is in DONE.
- stored, output, AW+1: number of samples held in the buffer.
- sample_cnt, output, 32: total samples seen.
- overflow, output, 1: at least one sample arrived while the buffer was full.
- lat_min, output, LAT_WIDTH: smallest sample seen.
- lat_max, output, LAT_WIDTH: largest sample seen.
- lat_sum, output, 48: sum of all samples counted.

Function
REQ-005 The block SHALL have three states: IDLE, RECORD and DONE.
REQ-006 Transitions:
- IDLE to RECORD on arm.
- RECORD to DONE on end_rd.
- DONE to RECORD on arm.
- Any state to IDLE on clear.
- When arm and clear are asserted together, clear SHALL win.
REQ-007 arm SHALL zero the following in the same edge that enters RECORD: stored, sample_cnt, overflow, lat_max, lat_sum. It SHALL set lat_min to all-ones. clear SHALL apply the same values.
REQ-008 In RECORD, on each cycle with lat_timer_valid, while stored < DEPTH:
- write lat_timer to buffer[stored];
- increment stored by 1 at the same edge.
REQ-009 In RECORD, on a valid sample with stored == DEPTH:
- the sample SHALL NOT be written;
- stored SHALL hold;
- overflow SHALL set and stay set until arm, clear or rst.
REQ-010 Statistics SHALL update on every valid sample in RECORD, including samples that overflow:
- sample_cnt +1;
- lat_sum + lat_timer;
- lat_min = min(lat_min, lat_timer);
- lat_max = max(lat_max, lat_timer).
All outputs SHALL reflect the sample on the cycle after it is accepted.
REQ-011 sample_cnt SHALL saturate at 2^32-1. Once it has saturated, lat_sum, lat_min and lat_max SHALL freeze. lat_sum SHALL therefore never wrap.
REQ-012 When lat_timer_valid and end_rd occur in the same cycle, the sample SHALL be recorded and the block SHALL then enter DONE.
REQ-013 In IDLE and DONE, lat_timer_valid SHALL be ignored. end_rd outside RECORD SHALL be ignored.
REQ-014 Readout SHALL be accepted in any state.
- rd_req at cycle N gives rd_valid = 1 at cycle N+1, for exactly one cycle per request.
- Back-to-back requests SHALL be supported, one per cycle.
REQ-015 rd_data SHALL be buffer[rd_addr] when rd_addr < stored; otherwise it SHALL be zero.
REQ-016 rd_data SHALL hold its value between requests.
REQ-017 A read and a write to the same address in the same cycle SHALL return the old buffer content.
REQ-018 The buffer SHALL be a single-write-port, single-read-port synchronous RAM with no reset of its contents.
REQ-019 busy and done SHALL be registered outputs decoded from the state.

Reset
REQ-020 When rst is asserted, the block SHALL immediately go to IDLE and set:
- busy, done, rd_valid, overflow = 0;
- stored, sample_cnt, lat_sum, lat_max, rd_data = 0;
- lat_min = all-ones.
REQ-021 Buffer contents SHALL be undefined after rst and SHALL NOT be readable, because stored = 0.
REQ-022 If rst is asserted during RECORD, the run SHALL be abandoned. A new arm SHALL be required before recording restarts.
REQ-023 On release of rst, the first clk edge SHALL be able to accept arm.

Verification
REQ-024 Basic run: arm; samples 100, 40, 250 on consecutive cycles; end_rd one cycle later. Required:
- done = 1;
- stored = 3, sample_cnt = 3;
- lat_min = 40, lat_max = 250, lat_sum = 390;
- reading address 1 returns 40 one cycle after rd_req.
REQ-025 Overflow (DEPTH = 16): arm; 20 samples of value 7. Required:
- stored = 16, sample_cnt = 20, overflow = 1, lat_sum = 140;
- reading address 15 returns 7;
- reading address 16 wraps to index 0 and returns 7. Repeat the run with 10 samples: reading address 12 returns 0.
REQ-026 Simultaneous events:
- lat_timer_valid with end_rd in the same cycle: sample counted and the block enters DONE.
- arm with clear in the same cycle: IDLE with statistics cleared.
- a sample arriving in DONE: no change to any output.
REQ-027 Reset mid-run: arm; 5 samples; assert rst asynchronously between edges. Required immediately: all outputs at their reset values. After release with no arm, samples SHALL be ignored.
REQ-028 Re-arm: DONE with stored = 3; arm; one sample of 9. Required: stored = 1, lat_min = lat_max = 9, overflow = 0, busy = 1.
